fibonacci_writer: RTL and testbench

Sequential Fibonacci generator that computes the sequence F(0), F(1), … term by term and writes each term into a synchronous RAM through a single write port. It is the write-side counterpart of the Fibonacci ROM read path: it fills a RAM with the same table that the ROM reader walks with its address counter. A start/done handshake is used on the control side, and a valid/ready handshake is used on the memory side.

---
 rtl/fib_pkg.sv | 15 +
 rtl/fibonacci_writer_if.sv | 29 ++
 rtl/fibonacci_writer.sv | 80 ++++++++
 tb/tb_fibonacci_writer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// fib_pkg: shared Fibonacci table types and default sizes.
// Used by the writer, the ROM reader and their benches.
package fib_pkg;

  localparam int FIB_DATA_W    = 24;
  localparam int FIB_ADDR_W    = 6;
  localparam int FIB_NUM_TERMS = 36;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } fib_state_e;

endpackage

// File: rtl/fibonacci_writer_if.sv
// fibonacci_writer_if: single RAM write port, valid/ready.
// master drives wren/wradr/wrdat, slave returns wr_ready.
interface fibonacci_writer_if
  import fib_pkg::*;
#(
  parameter int DATA_W = FIB_DATA_W,
  parameter int ADDR_W = FIB_ADDR_W
);

  logic              wren;
  logic              wr_ready;
  logic [ADDR_W-1:0] wradr;
  logic [DATA_W-1:0] wrdat;

  modport master (
    output wren,
    output wradr,
    output wrdat,
    input  wr_ready
  );

  modport slave (
    input  wren,
    input  wradr,
    input  wrdat,
    output wr_ready
  );

endinterface

// File: rtl/fibonacci_writer.sv
// fibonacci_writer: fills a RAM with F(0)..F(NUM_TERMS-1).
// Ports: clk, reset (async low), start, mem (write port), busy, done, overflow.
module fibonacci_writer
  import fib_pkg::*;
#(
  parameter int DATA_W    = FIB_DATA_W,
  parameter int ADDR_W    = FIB_ADDR_W,
  parameter int NUM_TERMS = FIB_NUM_TERMS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  fibonacci_writer_if.master mem,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_TERMS - 1);

  fib_state_e        state;
  logic [DATA_W-1:0] prev;
  logic [DATA_W-1:0] cur;
  logic [ADDR_W-1:0] adr;
  logic              ovf;
  logic [DATA_W:0]   sum;

  // Carry bit flags a next term that no longer fits.
  assign sum = {1'b0, prev} + {1'b0, cur};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      prev  <= '0;
      cur   <= '0;
      adr   <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= WRITE;
            prev  <= DATA_W'(1);
            cur   <= '0;
            adr   <= '0;
            ovf   <= 1'b0;
          end
        end
        WRITE: begin
          if (mem.wr_ready) begin
            prev <= cur;
            cur  <= sum[DATA_W-1:0];
            adr  <= adr + ADDR_W'(1);
            if (adr == LAST) begin
              state <= DONE;
            end else if (sum[DATA_W]) begin
              ovf   <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem.wren  = (state == WRITE);
  assign mem.wradr = adr;
  assign mem.wrdat = cur;
  assign busy      = (state == WRITE);
  assign done      = (state == DONE);
  assign overflow  = ovf;

endmodule

// File: tb/tb_fibonacci_writer.sv
// tb_fibonacci_writer: random-stall fill runs on two writers
// (36 terms, and 40 terms which overflows) against a Fibonacci model.
module tb_fibonacci_writer;
  import fib_pkg::*;

  localparam int DW   = 24;
  localparam int AW   = 6;
  localparam int NT_A = FIB_NUM_TERMS;
  localparam int NT_B = 40;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic wr_ready = 1'b0;
  logic busy_a, done_a, ovf_a;
  logic busy_b, done_b, ovf_b;

  fibonacci_writer_if #(.DATA_W(DW), .ADDR_W(AW)) mif_a ();
  fibonacci_writer_if #(.DATA_W(DW), .ADDR_W(AW)) mif_b ();

  assign mif_a.wr_ready = wr_ready;
  assign mif_b.wr_ready = wr_ready;

  fibonacci_writer #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_TERMS(NT_A)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start), .mem(mif_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a)
  );

  fibonacci_writer #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_TERMS(NT_B)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start), .mem(mif_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain Fibonacci arithmetic.
  function automatic longint fib(input int i);
    longint a, b, t;
    a = 0;
    b = 1;
    for (int k = 0; k < i; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int exp_writes(input int n, output bit o);
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (fib(i) >= (longint'(1) << DW)) begin
        o = 1'b1;
        return i;
      end
    end
    return n;
  endfunction

  // Write log, stall count, RAM image per writer.
  int          wcnt[2];
  int          stalls[2];
  int          dcnt[2];
  logic [AW-1:0] wadr[2][64];
  logic [DW-1:0] wdat[2][64];
  logic [DW-1:0] ram[2][64];
  bit          pend[2];
  logic [AW-1:0] p_adr[2];
  logic [DW-1:0] p_dat[2];

  task automatic mon(input int d, input logic wren,
                     input logic [AW-1:0] adr,
                     input logic [DW-1:0] dat,
                     input logic dn);
    if (pend[d]) begin
      check($sformatf("hold_adr%0d", d), adr, p_adr[d]);
      check($sformatf("hold_dat%0d", d), dat, p_dat[d]);
    end
    if (wren && wr_ready) begin
      ram[d][adr] = dat;
      if (wcnt[d] < 64) begin
        wadr[d][wcnt[d]] = adr;
        wdat[d][wcnt[d]] = dat;
      end
      wcnt[d]++;
    end
    if (wren && !wr_ready) stalls[d]++;
    pend[d] = wren && !wr_ready;
    p_adr[d] = adr;
    p_dat[d] = dat;
    if (dn) dcnt[d]++;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      mon(0, mif_a.wren, mif_a.wradr, mif_a.wrdat, done_a);
      mon(1, mif_b.wren, mif_b.wradr, mif_b.wrdat, done_b);
    end else begin
      pend[0] = 1'b0;
      pend[1] = 1'b0;
    end
  end

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin
      wcnt[d] = 0;
      stalls[d] = 0;
      dcnt[d] = 0;
      pend[d] = 1'b0;
      for (int i = 0; i < 64; i++) ram[d][i] = '0;
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_wren_a"}, mif_a.wren, 0);
    check({tag, "_adr_a"}, mif_a.wradr, 0);
    check({tag, "_dat_a"}, mif_a.wrdat, 0);
    check({tag, "_busy_a"}, busy_a, 0);
    check({tag, "_done_a"}, done_a, 0);
    check({tag, "_ovf_a"}, ovf_a, 0);
    check({tag, "_wren_b"}, mif_b.wren, 0);
    check({tag, "_done_b"}, done_b, 0);
    check({tag, "_ovf_b"}, ovf_b, 0);
  endtask

  function automatic logic pick_ready(input int mode, input int c);
    logic [3:0] pat;
    pat = 4'b1001;
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[3 - (c % 4)];
    return ($urandom_range(0, 3) != 0);
  endfunction

  // mode 0: ready always, 1: pattern 1,0,0,1, 2: random.
  task automatic run_fill(input int mode, input bit poke);
    int cyc;
    int done_at[2];
    logic ovf_at[2];
    int n, ew;
    bit eo;
    clear_logs();
    done_at[0] = -1;
    done_at[1] = -1;
    @(negedge clk);
    start = 1'b1;
    wr_ready = pick_ready(mode, 0);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("start_busy_a", busy_a, 1);
    check("start_wren_b", mif_b.wren, 1);
    check("start_ovf_clr_a", ovf_a, 0);
    check("start_ovf_clr_b", ovf_b, 0);
    while ((done_at[0] < 0 || done_at[1] < 0) && cyc < 400) begin
      wr_ready = pick_ready(mode, cyc);
      start = poke && (cyc == 12);
      @(negedge clk);
      cyc++;
      if (done_a && done_at[0] < 0) begin
        done_at[0] = cyc;
        ovf_at[0] = ovf_a;
      end
      if (done_b && done_at[1] < 0) begin
        done_at[1] = cyc;
        ovf_at[1] = ovf_b;
      end
    end
    start = 1'b0;
    if (cyc >= 400) check("timeout", 0, 1);
    @(negedge clk);
    check("end_busy_a", busy_a, 0);
    check("end_busy_b", busy_b, 0);
    for (int d = 0; d < 2; d++) begin
      n = (d == 0) ? NT_A : NT_B;
      ew = exp_writes(n, eo);
      check($sformatf("n_writes%0d", d), wcnt[d], ew);
      check($sformatf("ovf%0d", d), ovf_at[d], eo);
      check($sformatf("done_cnt%0d", d), dcnt[d], 1);
      check($sformatf("done_at%0d", d), done_at[d],
            ew + stalls[d] + 1);
      for (int i = 0; i < ew && i < wcnt[d] && i < 64; i++) begin
        check($sformatf("adr%0d_%0d", d, i), wadr[d][i], i);
        check($sformatf("dat%0d_%0d", d, i), wdat[d][i], fib(i));
      end
      if (ew < 64)
        check($sformatf("no_wr%0d_%0d", d, ew), ram[d][ew], 0);
      // Read-back loop over the RAM image.
      for (int i = 2; i < ew; i++)
        check($sformatf("ram_sum%0d_%0d", d, i), ram[d][i],
              longint'(ram[d][i-1]) + longint'(ram[d][i-2]));
    end
  endtask

  task automatic reset_mid_run();
    int g;
    clear_logs();
    @(negedge clk);
    start = 1'b1;
    wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (wcnt[0] < 10 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("rst_timeout", 0, 1);
    check("rst_at_idx", mif_a.wradr, 10);
    reset = 1'b0;
    #1;
    check_idle_zero("rst_mid");
    @(negedge clk);
    @(negedge clk);
    check("rst_no_done_a", dcnt[0], 0);
    check("rst_no_done_b", dcnt[1], 0);
    check_idle_zero("rst_hold");
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle_zero("idle");
    run_fill(0, 1'b0);
    run_fill(1, 1'b0);
    run_fill(2, 1'b1);
    run_fill(2, 1'b0);
    reset_mid_run();
    run_fill(0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
